// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and frame byte order for the boot loader
package imem_boot_loader_pkg;
    // Nine states are needed, so the encoding is 4 bits wide.
    typedef enum logic [3:0] {
        S_CNT   = 4'd0,
        S_HI    = 4'd1,
        S_LO    = 4'd2,
        S_WR    = 4'd3,
        S_SUM   = 4'd4,
        S_WAIT  = 4'd5,
        S_START = 4'd6,
        S_RUN   = 4'd7,
        S_ERR   = 4'd8
    } state_t;
    // Each instruction word arrives high byte first.
    localparam bit HI_FIRST = 1'b1;
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// boot_byte_packer: latches the hi/lo stream bytes and presents them as one instruction word
//   clock, reset     : clock, async active-high reset
//   load_hi, load_lo : capture byte_in as the high / low byte
//   byte_in          : stream byte
//   word             : assembled 16-bit word
module boot_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_hi,
    input  logic        load_lo,
    input  logic [7:0]  byte_in,
    output logic [15:0] word
);
    logic [7:0] hi, lo;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (load_hi) hi <= byte_in;
            if (load_lo) lo <= byte_in;
        end
    end
    assign word = HI_FIRST ? {hi, lo} : {lo, hi};
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a checksummed byte-stream image into i_memory, then enables and starts the CPU
//   clock, reset           : clock, async active-high reset
//   rx_valid/rx_data/rx_ready : byte stream handshake
//   mem_sel/mem_addr/mem_we/mem_dataout : i_memory write port (mem_sel=1 while loader owns it)
//   cpu_enable, cpu_start  : CPU enable level and one-cycle start pulse
//   load_err               : sticky checksum failure
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int START_DELAY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_dataout,
    output logic                  cpu_enable,
    output logic                  cpu_start,
    output logic                  load_err
);
    localparam int DW = $clog2(START_DELAY + 1);
    state_t state, next;
    logic [ADDR_WIDTH:0] index, n;
    logic [7:0] sum;
    logic [DW-1:0] dly;
    logic [15:0] word;
    logic accept, last;
    assign rx_ready = state inside {S_CNT, S_HI, S_LO, S_SUM};
    assign accept = rx_valid && rx_ready;
    assign last = index == n - 1'b1;
    assign mem_we = state == S_WR;
    assign mem_addr = mem_we ? index[ADDR_WIDTH-1:0] : '0;
    assign mem_dataout = mem_we ? DATA_WIDTH'(word) : '0;
    assign mem_sel = !(state inside {S_WAIT, S_START, S_RUN});
    assign cpu_enable = state inside {S_WAIT, S_START, S_RUN};
    assign cpu_start = state == S_START;
    assign load_err = state == S_ERR;
    boot_byte_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .load_hi (accept && state == S_HI),
        .load_lo (accept && state == S_LO),
        .byte_in (rx_data),
        .word    (word)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_CNT;
        else       state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            S_CNT:   next = accept ? S_HI : S_CNT;
            S_HI:    next = accept ? S_LO : S_HI;
            S_LO:    next = accept ? S_WR : S_LO;
            S_WR:    next = last ? S_SUM : S_HI;
            S_SUM:   next = !accept ? S_SUM : (sum == rx_data) ? S_WAIT : S_ERR;
            S_WAIT:  next = (dly == DW'(START_DELAY - 1)) ? S_START : S_WAIT;
            S_START: next = S_RUN;
            S_RUN:   next = S_RUN;
            S_ERR:   next = S_ERR;
            default: next = S_CNT;
        endcase
    end
    // COUNT seeds the running sum so the trailer check covers it as well as the data bytes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n     <= '0;
            index <= '0;
            sum   <= '0;
            dly   <= '0;
        end else begin
            case (state)
                S_CNT: if (accept) begin
                    n     <= (rx_data == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : (ADDR_WIDTH+1)'(rx_data);
                    index <= '0;
                    sum   <= rx_data;
                end
                S_HI, S_LO: if (accept) sum <= sum + rx_data;
                S_WR:    if (!last) index <= index + 1'b1;
                S_SUM:   dly <= '0;
                S_WAIT:  dly <= dly + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
